// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multi-cycle controller (master) and its datapath (slave).
interface multicycle_controller_if #(
   parameter int unsigned INSTR_WIDTH = 32
);
   logic [INSTR_WIDTH-1:0] instr_i;
   logic                   zero_i;
   logic                   mem_ready_i;
   logic                   PCWrite_o;
   logic                   AdrSrc_o;
   logic                   MemWrite_o;
   logic                   IRWrite_o;
   logic [1:0]             ResultSrc_o;
   logic [1:0]             ALUSrcA_o;
   logic [1:0]             ALUSrcB_o;
   logic [2:0]             ALUControl_o;
   logic [1:0]             ImmSrc_o;
   logic                   RegWrite_o;
   logic [3:0]             state_o;
   logic                   illegal_o;

   modport master (
      input  instr_i, zero_i, mem_ready_i,
      output PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o, ALUSrcA_o,
             ALUSrcB_o, ALUControl_o, ImmSrc_o, RegWrite_o, state_o, illegal_o
   );

   modport slave (
      output instr_i, zero_i, mem_ready_i,
      input  PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o, ALUSrcA_o,
             ALUSrcB_o, ALUControl_o, ImmSrc_o, RegWrite_o, state_o, illegal_o
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I subset core (lw, sw, R/I-ALU, beq, jal).
// Optional MC_ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP and raise illegal_o.
module multicycle_controller (
   input logic                     clk_i,
   input logic                     rst_i,
   multicycle_controller_if.master bus
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10
`ifdef MC_ILLEGAL_TRAP_EN
      , TRAP   = 4'd11
`endif
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_ALUI = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t     state_q, state_d;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5;
   logic [2:0] alu_funct;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_ctrl;
   logic       unused_instr;

   assign opcode       = bus.instr_i[6:0];
   assign funct3       = bus.instr_i[14:12];
   assign funct7_5     = bus.instr_i[30];
   assign unused_instr = ^{bus.instr_i[31], bus.instr_i[29:15], bus.instr_i[11:7]};

   // ALU operation for EXECUTER/EXECUTEI; only R-type may select sub via funct7[5]
   always_comb begin
      alu_funct = ALU_ADD;
      case (funct3)
         3'b000:  alu_funct = (opcode[5] & funct7_5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_funct = ALU_SLT;
         3'b110:  alu_funct = ALU_OR;
         3'b111:  alu_funct = ALU_AND;
         default: alu_funct = ALU_ADD;
      endcase
   end

   always_comb begin
      imm_src = 2'b00;
      case (opcode)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // Next state and per-state datapath selects
   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_ctrl   = ALU_ADD;
      case (state_q)
         FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_write   = bus.mem_ready_i;
            ir_write   = bus.mem_ready_i;
            if (bus.mem_ready_i) state_d = DECODE;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXECUTER;
               OP_ALUI:      state_d = EXECUTEI;
               OP_BEQ:       state_d = BEQ;
               OP_JAL:       state_d = JAL;
`ifdef MC_ILLEGAL_TRAP_EN
               default:      state_d = TRAP;
`else
               default:      state_d = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = opcode[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adr_src = 1'b1;
            if (bus.mem_ready_i) state_d = MEMWB;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_d    = FETCH;
         end
         MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (bus.mem_ready_i) state_d = FETCH;
         end
         EXECUTER: begin
            alu_src_a = 2'b10;
            alu_ctrl  = alu_funct;
            state_d   = ALUWB;
         end
         EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_ctrl  = alu_funct;
            state_d   = ALUWB;
         end
         ALUWB: begin
            reg_write = 1'b1;
            state_d   = FETCH;
         end
         BEQ: begin
            alu_src_a = 2'b10;
            alu_ctrl  = ALU_SUB;
            pc_write  = bus.zero_i;
            state_d   = FETCH;
         end
         JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            state_d   = ALUWB;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         TRAP:    state_d = TRAP;
`endif
         default: state_d = FETCH;
      endcase
      // An instruction abandoned by reset must not commit any write
      if (rst_i) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
      end
   end

`ifdef MC_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;

   assign illegal_d = illegal_q | (state_d == TRAP);

   always_ff @(posedge clk_i) begin
      if (rst_i) illegal_q <= 1'b0;
      else       illegal_q <= illegal_d;
   end

   assign bus.illegal_o = illegal_q;
`else
   assign bus.illegal_o = 1'b0;
`endif

   assign bus.PCWrite_o    = pc_write;
   assign bus.AdrSrc_o     = adr_src;
   assign bus.MemWrite_o   = mem_write;
   assign bus.IRWrite_o    = ir_write;
   assign bus.ResultSrc_o  = result_src;
   assign bus.ALUSrcA_o    = alu_src_a;
   assign bus.ALUSrcB_o    = alu_src_b;
   assign bus.ALUControl_o = alu_ctrl;
   assign bus.ImmSrc_o     = imm_src;
   assign bus.RegWrite_o   = reg_write;
   assign bus.state_o      = 4'(state_q);
endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: per-cycle vectors through a scoreboard queue,
// then latency measurements with mem_ready_i tied high.
module tb_multicycle_controller;
   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       irw;
      logic       mw;
      logic       rw;
      logic       adr;
      logic [1:0] res;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [2:0] alu;
      logic [1:0] imm;
      logic       ill;
   } out_t;

   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic        zero;
      logic        rdy;
      out_t        exp;
   } vec_t;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_SLT  = 32'h0020A1B3;
   localparam logic [31:0] I_OR   = 32'h0020E1B3;
   localparam logic [31:0] I_AND  = 32'h0020F1B3;
   localparam logic [31:0] I_SLL  = 32'h002091B3;
   localparam logic [31:0] I_ADDI = 32'h40508093;
   localparam logic [31:0] I_SW   = 32'h0030A223;
   localparam logic [31:0] I_LW   = 32'h0040A183;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_JAL  = 32'h008000EF;
   localparam logic [31:0] I_ILL  = 32'h0000007F;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;
   vec_t vecs[$];
   out_t sb_q[$];

   multicycle_controller_if #(.INSTR_WIDTH(32)) bus ();

   multicycle_controller dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic out_t mk(input logic [3:0] st, input logic pcw, input logic irw,
                               input logic mw, input logic rw, input logic adr,
                               input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
                               input logic [2:0] alu, input logic [1:0] imm, input logic ill);
      return {st, pcw, irw, mw, rw, adr, res, sa, sb, alu, imm, ill};
   endfunction

   function automatic out_t fe(input logic en, input logic [1:0] imm);
      return mk(4'd0, en, en, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0);
   endfunction
   function automatic out_t de(input logic [1:0] imm);
      return mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0);
   endfunction
   function automatic out_t ma(input logic [1:0] imm);
      return mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 1'b0);
   endfunction
   function automatic out_t mr(input logic [1:0] imm);
      return mk(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0);
   endfunction
   function automatic out_t mwb(input logic [1:0] imm);
      return mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, imm, 1'b0);
   endfunction
   function automatic out_t mwr(input logic [1:0] imm);
      return mk(4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0);
   endfunction
   function automatic out_t exr(input logic [2:0] alu, input logic [1:0] imm);
      return mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu, imm, 1'b0);
   endfunction
   function automatic out_t exi(input logic [2:0] alu, input logic [1:0] imm);
      return mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu, imm, 1'b0);
   endfunction
   function automatic out_t awb(input logic [1:0] imm);
      return mk(4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0);
   endfunction
   function automatic out_t bq(input logic z, input logic [1:0] imm);
      return mk(4'd9, z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, imm, 1'b0);
   endfunction
   function automatic out_t jl(input logic [1:0] imm);
      return mk(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, imm, 1'b0);
   endfunction
   function automatic out_t tr(input logic [1:0] imm);
      return mk(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b1);
   endfunction
   function automatic out_t gate(input out_t o);
      out_t r;
      r     = o;
      r.pcw = 1'b0;
      r.irw = 1'b0;
      r.mw  = 1'b0;
      r.rw  = 1'b0;
      return r;
   endfunction

   task automatic add(input logic r, input logic [31:0] ins, input logic z, input logic rd,
                      input out_t e);
      vec_t v;
      v.rst   = r;
      v.instr = ins;
      v.zero  = z;
      v.rdy   = rd;
      v.exp   = e;
      vecs.push_back(v);
   endtask

   // R-type sequence; mem_ready_i low in DECODE/EXECUTER must not stall
   task automatic add_rtype(input logic [31:0] ins, input logic [2:0] alu);
      add(1'b0, ins, 1'b0, 1'b1, fe(1'b1, 2'b00));
      add(1'b0, ins, 1'b0, 1'b0, de(2'b00));
      add(1'b0, ins, 1'b1, 1'b0, exr(alu, 2'b00));
      add(1'b0, ins, 1'b0, 1'b1, awb(2'b00));
   endtask

   task automatic build();
      add(1'b1, I_ADD, 1'b0, 1'b1, gate(fe(1'b1, 2'b00)));
      add(1'b1, I_ADD, 1'b0, 1'b1, gate(fe(1'b1, 2'b00)));
      add_rtype(I_ADD, 3'b000);
      add_rtype(I_SUB, 3'b001);
      // sw: FETCH stall, then MEMWRITE stalled three cycles
      add(1'b0, I_SW, 1'b0, 1'b0, fe(1'b0, 2'b01));
      add(1'b0, I_SW, 1'b0, 1'b1, fe(1'b1, 2'b01));
      add(1'b0, I_SW, 1'b0, 1'b0, de(2'b01));
      add(1'b0, I_SW, 1'b0, 1'b0, ma(2'b01));
      add(1'b0, I_SW, 1'b0, 1'b0, mwr(2'b01));
      add(1'b0, I_SW, 1'b0, 1'b0, mwr(2'b01));
      add(1'b0, I_SW, 1'b0, 1'b0, mwr(2'b01));
      add(1'b0, I_SW, 1'b0, 1'b1, mwr(2'b01));
      // lw with one MEMREAD stall
      add(1'b0, I_LW, 1'b0, 1'b1, fe(1'b1, 2'b00));
      add(1'b0, I_LW, 1'b0, 1'b1, de(2'b00));
      add(1'b0, I_LW, 1'b0, 1'b0, ma(2'b00));
      add(1'b0, I_LW, 1'b0, 1'b0, mr(2'b00));
      add(1'b0, I_LW, 1'b0, 1'b1, mr(2'b00));
      add(1'b0, I_LW, 1'b0, 1'b0, mwb(2'b00));
      // beq taken then not taken
      add(1'b0, I_BEQ, 1'b0, 1'b1, fe(1'b1, 2'b10));
      add(1'b0, I_BEQ, 1'b0, 1'b0, de(2'b10));
      add(1'b0, I_BEQ, 1'b1, 1'b1, bq(1'b1, 2'b10));
      add(1'b0, I_BEQ, 1'b0, 1'b1, fe(1'b1, 2'b10));
      add(1'b0, I_BEQ, 1'b1, 1'b1, de(2'b10));
      add(1'b0, I_BEQ, 1'b0, 1'b1, bq(1'b0, 2'b10));
      // jal
      add(1'b0, I_JAL, 1'b0, 1'b1, fe(1'b1, 2'b11));
      add(1'b0, I_JAL, 1'b0, 1'b1, de(2'b11));
      add(1'b0, I_JAL, 1'b0, 1'b0, jl(2'b11));
      add(1'b0, I_JAL, 1'b0, 1'b1, awb(2'b11));
      // I-type with bit 30 set still adds
      add(1'b0, I_ADDI, 1'b0, 1'b1, fe(1'b1, 2'b00));
      add(1'b0, I_ADDI, 1'b0, 1'b1, de(2'b00));
      add(1'b0, I_ADDI, 1'b0, 1'b1, exi(3'b000, 2'b00));
      add(1'b0, I_ADDI, 1'b0, 1'b1, awb(2'b00));
      add_rtype(I_SLT, 3'b101);
      add_rtype(I_OR,  3'b011);
      add_rtype(I_AND, 3'b010);
      add_rtype(I_SLL, 3'b000);
      // unknown opcode
      add(1'b0, I_ILL, 1'b0, 1'b1, fe(1'b1, 2'b00));
      add(1'b0, I_ILL, 1'b0, 1'b1, de(2'b00));
`ifdef MC_ILLEGAL_TRAP_EN
      add(1'b0, I_ILL, 1'b0, 1'b1, tr(2'b00));
      add(1'b0, I_ILL, 1'b0, 1'b1, tr(2'b00));
      add(1'b0, I_ILL, 1'b0, 1'b1, tr(2'b00));
      add(1'b1, I_ILL, 1'b0, 1'b1, tr(2'b00));
`endif
      // reset during MEMWB suppresses RegWrite
      add(1'b0, I_LW, 1'b0, 1'b1, fe(1'b1, 2'b00));
      add(1'b0, I_LW, 1'b0, 1'b1, de(2'b00));
      add(1'b0, I_LW, 1'b0, 1'b1, ma(2'b00));
      add(1'b0, I_LW, 1'b0, 1'b1, mr(2'b00));
      add(1'b1, I_LW, 1'b0, 1'b1, gate(mwb(2'b00)));
      // reset during MEMWRITE suppresses MemWrite
      add(1'b0, I_SW, 1'b0, 1'b1, fe(1'b1, 2'b01));
      add(1'b0, I_SW, 1'b0, 1'b1, de(2'b01));
      add(1'b0, I_SW, 1'b0, 1'b1, ma(2'b01));
      add(1'b1, I_SW, 1'b0, 1'b0, gate(mwr(2'b01)));
      add(1'b0, I_SW, 1'b0, 1'b0, fe(1'b0, 2'b01));
   endtask

   task automatic check(input out_t e, input int idx);
      out_t a;
      a = {bus.state_o, bus.PCWrite_o, bus.IRWrite_o, bus.MemWrite_o, bus.RegWrite_o,
           bus.AdrSrc_o, bus.ResultSrc_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALUControl_o,
           bus.ImmSrc_o, bus.illegal_o};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL vec%0d state=%0d/%0d outputs got=%h exp=%h", idx, a.st, e.st, a, e);
   endtask

   // Entered in a FETCH cycle; counts cycles until FETCH comes round again
   task automatic measure(input logic [31:0] ins, input int lat);
      int  n;
      bit  done;
      bit  started;
      started         = (bus.state_o == 4'd0);
      bus.instr_i     = ins;
      bus.mem_ready_i = 1'b1;
      bus.zero_i      = 1'b0;
      n               = 1;
      done            = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(posedge clk);
         #1;
         if (bus.state_o == 4'd0) done = 1'b1;
         else                     n++;
      end
      n_checks++;
      if (started && done && n == lat) n_pass++;
      else $display("FAIL latency instr=%h got=%0d exp=%0d (ended=%0b)", ins, n, lat, done);
   endtask

   initial begin
      bus.instr_i     = I_ADD;
      bus.zero_i      = 1'b0;
      bus.mem_ready_i = 1'b1;
      rst             = 1'b1;
      build();
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         rst             = vecs[i].rst;
         bus.instr_i     = vecs[i].instr;
         bus.zero_i      = vecs[i].zero;
         bus.mem_ready_i = vecs[i].rdy;
         sb_q.push_back(vecs[i].exp);
         @(negedge clk);
         check(sb_q.pop_front(), i);
      end
      @(posedge clk);
      #1;
      measure(I_LW,   5);
      measure(I_SW,   4);
      measure(I_ADD,  4);
      measure(I_ADDI, 4);
      measure(I_BEQ,  3);
      measure(I_JAL,  4);
`ifndef MC_ILLEGAL_TRAP_EN
      measure(I_ILL,  2);
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d/%0d checks", n_pass, n_checks);
      $fatal(1, "watchdog");
   end
endmodule
